// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: FSM state
// encoding and the default datapath widths used by the arbiter.
package regfile_pkg;

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } wb_state_e;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 5;
    localparam int DEF_NUM_REGS      = 32;
    localparam int DEF_NUM_REQ       = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: returns a one-hot grant for the first
// requester found searching ptr, ptr+1, ... modulo N, plus its index.
// Holds no state; the caller owns and advances the priority pointer.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o
);

    // Walk offsets from farthest to nearest so the nearest requester to ptr wins.
    always_comb begin
        int j;
        j           = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                grant_o     = '0;
                grant_o[j]  = 1'b1;
                grant_idx_o = PW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owner of the register-file write port. Shares it round-robin between the
// writeback sources and, after reset or on scrub_req, zeroes registers
// 1..NUM_REGS-1 through the same port before normal traffic resumes.
//
// Handshake: a source raises req_valid[i] with req_dest/req_data stable and
// keeps them until it sees req_ready[i]; a transfer happens in any cycle
// where req_valid[i] & req_ready[i]. req_ready is combinational, at most one
// bit high, and is forced low while scrubbing or when scrub_req is raised.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int NUM_REGS      = DEF_NUM_REGS,
    parameter int NUM_REQ       = DEF_NUM_REQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             scrub_req,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             busy,
    output logic                             rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]            rg_wrt_data,
    output wb_state_e                        dbg_state_o
);

    localparam int PW = $clog2(NUM_REQ);
    localparam logic [ADDRESS_WIDTH-1:0] FIRST_IDX = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX  = ADDRESS_WIDTH'(NUM_REGS - 1);

    wb_state_e                state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] scrub_idx_q, scrub_idx_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
    logic                     en_q, en_d;
    logic [ADDRESS_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     busy_q, busy_d;

    logic [NUM_REQ-1:0]       grant;
    logic [PW-1:0]            grant_idx;
    logic                     arb_en;
    logic                     xfer;
    logic [ADDRESS_WIDTH-1:0] sel_dest;
    logic [DATA_WIDTH-1:0]    sel_data;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    // Expose the grant only in RUN and not in a cycle that starts a scrub,
    // so a pending request is held until the scrub completes.
    always_comb begin
        arb_en    = (state_q == RUN) && !scrub_req;
        req_ready = arb_en ? grant : '0;
        xfer      = |req_ready;
        sel_dest  = req_dest[int'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_data  = req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    // Next-state, scrub counter, pointer and write-port values.
    always_comb begin
        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        rr_ptr_d    = rr_ptr_q;
        en_d        = 1'b0;
        dest_d      = dest_q;
        data_d      = data_q;
        case (state_q)
            SCRUB: begin
                en_d   = 1'b1;
                dest_d = scrub_idx_q;
                data_d = '0;
                if (scrub_req) begin
                    scrub_idx_d = FIRST_IDX;
                end else if (scrub_idx_q == LAST_IDX) begin
                    state_d     = RUN;
                    scrub_idx_d = FIRST_IDX;
                end else begin
                    scrub_idx_d = scrub_idx_q + ADDRESS_WIDTH'(1);
                end
            end
            default: begin
                if (scrub_req) begin
                    state_d     = SCRUB;
                    scrub_idx_d = FIRST_IDX;
                end else if (xfer) begin
                    rr_ptr_d = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
                    // x0 is hardwired: the handshake completes but nothing is written.
                    if (sel_dest != '0) begin
                        en_d   = 1'b1;
                        dest_d = sel_dest;
                        data_d = sel_data;
                    end
                end
            end
        endcase
        // busy stays high until the final scrub write has reached the port.
        busy_d = (state_q == SCRUB) || (state_d == SCRUB);
    end

    // Registered FSM state, counters and write-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SCRUB;
            scrub_idx_q <= FIRST_IDX;
            rr_ptr_q    <= '0;
            en_q        <= 1'b0;
            dest_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            scrub_idx_q <= scrub_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            en_q        <= en_d;
            dest_q      <= dest_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
        end
    end

    assign rg_wrt_en   = en_q;
    assign rg_wrt_dest = dest_q;
    assign rg_wrt_data = data_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule
